// File: rtl/softex_lane_splitter.sv
// rtl/softex_lane_splitter.sv - stride-interleaving element splitter feeding NUM_LANES softex lanes
// Optional perf counters (stall_cnt_o, beat_cnt_o) are enabled by SOFTEX_LANE_SPLITTER_PERF_EN.
module softex_lane_splitter #(
  parameter int unsigned DATA_WIDTH      = 128,
  parameter int unsigned ELEM_WIDTH      = 16,
  parameter int unsigned NUM_LANES       = 2,
  parameter int unsigned LANE_WIDTH      = DATA_WIDTH / NUM_LANES,
  parameter int unsigned LANE_FIFO_DEPTH = 2,
  parameter int unsigned LEN_WIDTH       = 32
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              clear_i,
  input  logic                              start_i,
  input  logic [LEN_WIDTH-1:0]              len_i,
  output logic                              busy_o,
  output logic                              done_o,
  input  logic [DATA_WIDTH-1:0]             in_data_i,
  input  logic [DATA_WIDTH/8-1:0]           in_strb_i,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  output logic [NUM_LANES*LANE_WIDTH-1:0]   lane_data_o,
  output logic [NUM_LANES*LANE_WIDTH/8-1:0] lane_strb_o,
  output logic [NUM_LANES-1:0]              lane_valid_o,
  input  logic [NUM_LANES-1:0]              lane_ready_i
`ifdef SOFTEX_LANE_SPLITTER_PERF_EN
  ,
  output logic [31:0]                       stall_cnt_o,
  output logic [31:0]                       beat_cnt_o
`endif
);
  localparam int unsigned EPB = DATA_WIDTH / ELEM_WIDTH;
  localparam int unsigned EPL = EPB / NUM_LANES;
  localparam int unsigned EB  = ELEM_WIDTH / 8;
  localparam int unsigned LSW = LANE_WIDTH / 8;
  localparam int unsigned PW  = (LANE_FIFO_DEPTH > 1) ? $clog2(LANE_FIFO_DEPTH) : 1;
  localparam int unsigned CW  = $clog2(LANE_FIFO_DEPTH + 1);

  if (LANE_WIDTH != DATA_WIDTH / NUM_LANES) begin : g_bad_lane_width
    $error("LANE_WIDTH must equal DATA_WIDTH/NUM_LANES");
  end
  if ((DATA_WIDTH % ELEM_WIDTH) != 0 || (ELEM_WIDTH % 8) != 0 ||
      (EPL * NUM_LANES) != EPB || LANE_FIFO_DEPTH < 1) begin : g_bad_cfg
    $error("invalid softex_lane_splitter configuration");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

  state_e                          r_state;
  logic [LEN_WIDTH-1:0]            r_remaining;
  logic                            r_done;
  logic                            w_clr;
  logic                            w_accept;
  logic [LEN_WIDTH-1:0]            w_rem_next;
  logic [NUM_LANES-1:0]            w_has_space;
  logic [NUM_LANES-1:0]            w_nonempty;
  logic [NUM_LANES*LANE_WIDTH-1:0] w_lane_data;
  logic [NUM_LANES*LSW-1:0]        w_lane_strb;

  assign w_clr      = !rst_ni || clear_i;
  assign in_ready_o = (r_state == ST_RUN) && (&w_has_space);
  assign w_accept   = in_valid_i && in_ready_o;
  assign w_rem_next = (r_remaining > LEN_WIDTH'(EPB)) ? r_remaining - LEN_WIDTH'(EPB) : '0;
  assign busy_o     = (r_state != ST_IDLE);
  assign done_o     = r_done;

  // Element e = s*NUM_LANES + l lands in lane l, slot s; strobes beyond the job length are cleared.
  always_comb begin
    w_lane_data = '0;
    w_lane_strb = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      for (int s = 0; s < EPL; s++) begin
        w_lane_data[l*LANE_WIDTH + s*ELEM_WIDTH +: ELEM_WIDTH] =
          in_data_i[(s*NUM_LANES + l)*ELEM_WIDTH +: ELEM_WIDTH];
        w_lane_strb[l*LSW + s*EB +: EB] = in_strb_i[(s*NUM_LANES + l)*EB +: EB] &
          {EB{r_remaining > LEN_WIDTH'(s*NUM_LANES + l)}};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_clr) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: if (start_i) begin
          if (len_i != '0) begin
            r_remaining <= len_i;
            r_state     <= ST_RUN;
          end else begin
            r_done <= 1'b1;
          end
        end
        ST_RUN: if (w_accept) begin
          r_remaining <= w_rem_next;
          if (r_remaining <= LEN_WIDTH'(EPB)) r_state <= ST_DRAIN;
        end
        ST_DRAIN: if (~|w_nonempty) begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Independent per-lane FIFOs; all are written together, each drains at its own pace.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [LANE_WIDTH-1:0] r_mem_data [LANE_FIFO_DEPTH];
    logic [LSW-1:0]        r_mem_strb [LANE_FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  w_pop;

    assign w_has_space[l] = (r_count < CW'(LANE_FIFO_DEPTH));
    assign w_nonempty[l]  = (r_count != '0);
    assign w_pop          = w_nonempty[l] && lane_ready_i[l];

    always_ff @(posedge clk_i) begin
      if (w_clr) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_accept) begin
          r_mem_data[r_wr_ptr] <= w_lane_data[l*LANE_WIDTH +: LANE_WIDTH];
          r_mem_strb[r_wr_ptr] <= w_lane_strb[l*LSW +: LSW];
          r_wr_ptr <= (r_wr_ptr == PW'(LANE_FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= (r_rd_ptr == PW'(LANE_FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
        end
        r_count <= r_count + CW'(w_accept) - CW'(w_pop);
      end
    end

    assign lane_valid_o[l]                         = w_nonempty[l];
    assign lane_data_o[l*LANE_WIDTH +: LANE_WIDTH] = w_nonempty[l] ? r_mem_data[r_rd_ptr] : '0;
    assign lane_strb_o[l*LSW +: LSW]               = w_nonempty[l] ? r_mem_strb[r_rd_ptr] : '0;
  end

`ifdef SOFTEX_LANE_SPLITTER_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_beat_cnt;

  always_ff @(posedge clk_i) begin
    if (w_clr || (r_state == ST_IDLE && start_i)) begin
      r_stall_cnt <= '0;
      r_beat_cnt  <= '0;
    end else begin
      if (r_state == ST_RUN && in_valid_i && !in_ready_o && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_accept && r_beat_cnt != '1)
        r_beat_cnt <= r_beat_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign beat_cnt_o  = r_beat_cnt;
`endif
endmodule
